tnew_tracker: RTL and testbench

- Producer-side counterpart of the D-stage Tuse decode in the 5-stage MIPS pipeline.
- Carries each in-flight instruction's destination register (A3) and Tnew (cycles until its result is available) through the E, M and W stages, counting Tnew down as the instruction advances.
- Compares the current D-stage Tuse values against those records and produces the pipeline stall and the D-stage rs/rt forwarding selects.

---
 rtl/tnew_tracker_pkg.sv | 23 ++
 rtl/tnew_tracker_fwd_sel.sv | 60 ++++++
 rtl/tnew_tracker.sv | 108 ++++++++++
 tb/tb_tnew_tracker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tnew_tracker_pkg.sv
// -----------------------------------------------------------------------------
// tnew_tracker_pkg
// Shared constants for the producer-side Tnew tracker of the 5-stage MIPS
// pipeline: forwarding-select encodings, the "operand not used" Tuse marker
// and the Tnew values each instruction class carries into the E stage.
// -----------------------------------------------------------------------------
package tnew_tracker_pkg;

  // D-stage forwarding source select.
  localparam logic [1:0] FWD_RF = 2'd0;  // register file, no bypass
  localparam logic [1:0] FWD_W  = 2'd1;  // bypass from W-stage result
  localparam logic [1:0] FWD_M  = 2'd2;  // bypass from M-stage result
  localparam logic [1:0] FWD_E  = 2'd3;  // bypass from E-stage result

  // Tuse value marking an operand the D-stage instruction does not read.
  localparam logic [2:0] TUSE_NOUSE = 3'b111;

  // Tnew at E-stage entry for each producer class.
  localparam logic [1:0] TNEW_ALU  = 2'd1;  // ALU ops, ori, lui
  localparam logic [1:0] TNEW_LOAD = 2'd2;  // lw
  localparam logic [1:0] TNEW_LINK = 2'd0;  // jal: PC+8 is known at E entry

endpackage

// File: rtl/tnew_tracker_fwd_sel.sv
// -----------------------------------------------------------------------------
// tnew_fwd_sel
// Hazard resolution for one D-stage source operand. Matches the operand
// address against the E/M/W destination records and produces the forwarding
// select (youngest match wins) plus a stall request when the youngest
// producer's result arrives later than the operand is needed.
//
// Ports:
//   r         in   operand register address
//   tuse      in   cycles until the operand is needed (all-ones = unused)
//   e_a3/e_tnew, m_a3/m_tnew, w_a3   in   stage records
//   fwd       out  forwarding select (FWD_RF/W/M/E)
//   stall_req out  this operand cannot be satisfied in time
// -----------------------------------------------------------------------------
module tnew_fwd_sel
  import tnew_tracker_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int TNEW_W = 2,
  parameter int TUSE_W = 3
) (
  input  logic [REG_AW-1:0] r,
  input  logic [TUSE_W-1:0] tuse,
  input  logic [REG_AW-1:0] e_a3,
  input  logic [TNEW_W-1:0] e_tnew,
  input  logic [REG_AW-1:0] m_a3,
  input  logic [TNEW_W-1:0] m_tnew,
  input  logic [REG_AW-1:0] w_a3,
  output logic [1:0]        fwd,
  output logic              stall_req
);

  logic e_hit, m_hit, w_hit, used;

  // $0 is hard-wired zero, so a record writing it never produces a value.
  assign e_hit = (e_a3 != '0) && (e_a3 == r);
  assign m_hit = (m_a3 != '0) && (m_a3 == r);
  assign w_hit = (w_a3 != '0) && (w_a3 == r);
  assign used  = ~&tuse;

  // Tnew is zero-extended so the compare is unsigned at Tuse width.
  assign stall_req = used &&
                     ((e_hit && (tuse < TUSE_W'(e_tnew))) ||
                      (m_hit && (tuse < TUSE_W'(m_tnew))));

  // A younger match that is not ready yet hides older matches: their value
  // is stale, so the select falls back to RF and the stall covers it.
  always_comb begin
    // NOTE: default assignment first so no path leaves fwd unassigned (no latch).
    fwd = FWD_RF;
    if (e_hit) begin
      if (e_tnew == '0) fwd = FWD_E;
    end else if (m_hit) begin
      if (m_tnew == '0) fwd = FWD_M;
    end else if (w_hit) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/tnew_tracker.sv
// -----------------------------------------------------------------------------
// tnew_tracker
// Carries each in-flight instruction's destination register (A3) and Tnew
// through E, M and W, counting Tnew down as it advances, and compares the
// D-stage Tuse values against those records to produce the pipeline stall
// and the D-stage rs/rt forwarding selects.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   d_a3, d_tnew            D-stage destination register and Tnew at E entry
//   d_rs, d_rt              D-stage source registers
//   tuse_rs, tuse_rt        D-stage Tuse per operand (all-ones = unused)
//   stall                   freeze PC and F/D, bubble into E (combinational)
//   fwd_rs, fwd_rt          forwarding selects: 0=RF 1=W 2=M 3=E
//   e_a3, m_a3, w_a3        stage destination records (debug)
//   e_tnew, m_tnew          stage Tnew records (debug)
//   stall_cnt               stalled-cycle counter, only with TNEW_STALL_CNT_EN
//
// Build option: define TNEW_STALL_CNT_EN to add the 32-bit stall_cnt output.
// -----------------------------------------------------------------------------
module tnew_tracker #(
  parameter int REG_AW = 5,
  parameter int TNEW_W = 2,
  parameter int TUSE_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] d_a3,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TUSE_W-1:0] tuse_rs,
  input  logic [TUSE_W-1:0] tuse_rt,
  output logic              stall,
  output logic [1:0]        fwd_rs,
  output logic [1:0]        fwd_rt,
  output logic [REG_AW-1:0] e_a3,
  output logic [REG_AW-1:0] m_a3,
  output logic [REG_AW-1:0] w_a3,
  output logic [TNEW_W-1:0] e_tnew,
  output logic [TNEW_W-1:0] m_tnew
`ifdef TNEW_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  logic stall_rs, stall_rt;

  tnew_fwd_sel #(.REG_AW(REG_AW), .TNEW_W(TNEW_W), .TUSE_W(TUSE_W)) u_sel_rs (
    .r         (d_rs),
    .tuse      (tuse_rs),
    .e_a3      (e_a3),
    .e_tnew    (e_tnew),
    .m_a3      (m_a3),
    .m_tnew    (m_tnew),
    .w_a3      (w_a3),
    .fwd       (fwd_rs),
    .stall_req (stall_rs)
  );

  tnew_fwd_sel #(.REG_AW(REG_AW), .TNEW_W(TNEW_W), .TUSE_W(TUSE_W)) u_sel_rt (
    .r         (d_rt),
    .tuse      (tuse_rt),
    .e_a3      (e_a3),
    .e_tnew    (e_tnew),
    .m_a3      (m_a3),
    .m_tnew    (m_tnew),
    .w_a3      (w_a3),
    .fwd       (fwd_rt),
    .stall_req (stall_rt)
  );

  assign stall = stall_rs | stall_rt;

  // M and W always advance; a stall only replaces the D->E transfer with a
  // bubble, which lets a pending producer keep draining its Tnew.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_a3   <= '0;
      e_tnew <= '0;
      m_a3   <= '0;
      m_tnew <= '0;
      w_a3   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge values.
      w_a3   <= m_a3;
      m_a3   <= e_a3;
      m_tnew <= (e_tnew == '0) ? '0 : e_tnew - 1'b1;
      if (stall) begin
        e_a3   <= '0;
        e_tnew <= '0;
      end else begin
        e_a3   <= d_a3;
        e_tnew <= d_tnew;
      end
    end
  end

`ifdef TNEW_STALL_CNT_EN
  // Free-running count of stalled cycles; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt <= '0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_tnew_tracker.sv
// -----------------------------------------------------------------------------
// tb_tnew_tracker
// Self-checking bench for tnew_tracker: a directed table of instruction
// sequences, an asynchronous reset taken in the middle of a stall, then
// random traffic checked against an age-based reference model.
// -----------------------------------------------------------------------------
module tb_tnew_tracker;
  import tnew_tracker_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] d_a3, d_rs, d_rt;
  logic [1:0] d_tnew;
  logic [2:0] tuse_rs, tuse_rt;
  logic       stall;
  logic [1:0] fwd_rs, fwd_rt;
  logic [4:0] e_a3, m_a3, w_a3;
  logic [1:0] e_tnew, m_tnew;
`ifdef TNEW_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  tnew_tracker dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d_a3    (d_a3),
    .d_tnew  (d_tnew),
    .d_rs    (d_rs),
    .d_rt    (d_rt),
    .tuse_rs (tuse_rs),
    .tuse_rt (tuse_rt),
    .stall   (stall),
    .fwd_rs  (fwd_rs),
    .fwd_rt  (fwd_rt),
    .e_a3    (e_a3),
    .m_a3    (m_a3),
    .w_a3    (w_a3),
    .e_tnew  (e_tnew),
    .m_tnew  (m_tnew)
`ifdef TNEW_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: remembers what entered E over the last three cycles,
  // indexed by age (0 = now in E, 1 = in M, 2 = in W). Remaining Tnew is the
  // entry Tnew minus the age, floored at zero; W is always ready.
  int hist_a3 [3];
  int hist_t0 [3];
  int model_stalls;

  function automatic int remain(input int age);
    int t;
    if (age >= 2) return 0;
    t = hist_t0[age] - age;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic bit holds(input int age, input int r);
    return (hist_a3[age] != 0) && (hist_a3[age] == r);
  endfunction

  function automatic bit model_stall();
    for (int age = 0; age < 2; age++) begin
      if (holds(age, d_rs) && tuse_rs != TUSE_NOUSE && int'(tuse_rs) < remain(age)) return 1'b1;
      if (holds(age, d_rt) && tuse_rt != TUSE_NOUSE && int'(tuse_rt) < remain(age)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int model_fwd(input int r);
    for (int age = 0; age < 3; age++)
      if (holds(age, r)) return (remain(age) == 0) ? (3 - age) : 0;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hist_a3[i] = 0;
      hist_t0[i] = 0;
    end
    model_stalls = 0;
  endtask

  // Called at a negedge with inputs already applied: check, clock, advance model.
  task automatic cycle(input string tag, input bit chk_out);
    bit s;
    #1;
    s = model_stall();
    check({tag, " e_a3"},   32'(e_a3),   32'(hist_a3[0]));
    check({tag, " e_tnew"}, 32'(e_tnew), 32'(remain(0)));
    check({tag, " m_a3"},   32'(m_a3),   32'(hist_a3[1]));
    check({tag, " m_tnew"}, 32'(m_tnew), 32'(remain(1)));
    check({tag, " w_a3"},   32'(w_a3),   32'(hist_a3[2]));
    if (chk_out) begin
      check({tag, " stall"}, 32'(stall), 32'(s));
      if (!s) begin
        check({tag, " fwd_rs"}, 32'(fwd_rs), 32'(model_fwd(d_rs)));
        check({tag, " fwd_rt"}, 32'(fwd_rt), 32'(model_fwd(d_rt)));
      end
    end
`ifdef TNEW_STALL_CNT_EN
    check({tag, " stall_cnt"}, stall_cnt, 32'(model_stalls));
`endif
    @(posedge clk);
    hist_a3[2] = hist_a3[1];
    hist_t0[2] = hist_t0[1];
    hist_a3[1] = hist_a3[0];
    hist_t0[1] = hist_t0[0];
    hist_a3[0] = s ? 0 : int'(d_a3);
    hist_t0[0] = s ? 0 : int'(d_tnew);
    if (s) model_stalls++;
    @(negedge clk);
  endtask

  task automatic drive(input int a3, input int tn, input int rs, input int rt,
                       input int urs, input int urt);
    d_a3    = 5'(a3);
    d_tnew  = 2'(tn);
    d_rs    = 5'(rs);
    d_rt    = 5'(rt);
    tuse_rs = 3'(urs);
    tuse_rt = 3'(urt);
  endtask

  typedef struct {
    int a3, tnew, rs, rt, urs, urt;
    int stall, frs, frt;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // load-use: lw $8; add rs=$8 (Tuse 1) -> one stall cycle
    tbl[0]  = '{8, 2, 0, 0, 7, 7, 0, 0, 0};
    tbl[1]  = '{10, 1, 8, 0, 1, 1, 1, 0, 0};
    tbl[2]  = '{10, 1, 8, 0, 1, 1, 0, 0, 0};
    // load-branch: lw $8; beq rs=$8 (Tuse 0) -> two stalls, then W bypass
    tbl[3]  = '{8, 2, 0, 0, 7, 7, 0, 0, 0};
    tbl[4]  = '{0, 0, 8, 0, 0, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 8, 0, 0, 0, 1, 0, 0};
    tbl[6]  = '{0, 0, 8, 0, 0, 0, 0, 1, 0};
    // ALU-ALU: ori $9; consumers of rt=$9 see E(not ready), M, then W
    tbl[7]  = '{9, 1, 0, 0, 7, 7, 0, 0, 0};
    tbl[8]  = '{11, 1, 0, 9, 1, 1, 0, 0, 0};
    tbl[9]  = '{12, 1, 0, 9, 1, 1, 0, 0, 2};
    tbl[10] = '{0, 0, 0, 9, 7, 1, 0, 0, 1};
    // $0 producer and consumer never match
    tbl[11] = '{0, 1, 0, 0, 7, 7, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    // unused operand matching a pending load does not stall
    tbl[13] = '{13, 2, 0, 0, 7, 7, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 13, 7, 7, 0, 0, 0};
    // priority: E and M both hold ready $5 -> E wins
    tbl[15] = '{5, 0, 0, 0, 7, 7, 0, 0, 0};
    tbl[16] = '{5, 0, 0, 0, 7, 7, 0, 0, 0};
    tbl[17] = '{0, 0, 5, 13, 0, 0, 0, 3, 0};

    model_reset();
    drive(0, 0, 0, 0, 7, 7);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset e_a3", 32'(e_a3), 32'd0);
    check("reset m_tnew", 32'(m_tnew), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].a3, tbl[i].tnew, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt);
      #1;
      check($sformatf("vec%0d stall", i), 32'(stall), 32'(tbl[i].stall));
      check($sformatf("vec%0d fwd_rs", i), 32'(fwd_rs), 32'(tbl[i].frs));
      check($sformatf("vec%0d fwd_rt", i), 32'(fwd_rt), 32'(tbl[i].frt));
      cycle($sformatf("vec%0d", i), 1'b0);
    end
`ifdef TNEW_STALL_CNT_EN
    check("stall_cnt after load seqs", stall_cnt, 32'd3);
`endif

    // Asynchronous reset taken mid-way through a lw -> beq stall.
    drive(8, TNEW_LOAD, 0, 0, 7, 7);
    cycle("rst lw", 1'b1);
    drive(0, 0, 8, 0, 0, 0);
    #1;
    check("rst pre stall", 32'(stall), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst stall", 32'(stall), 32'd0);
    check("rst e_a3", 32'(e_a3), 32'd0);
    check("rst e_tnew", 32'(e_tnew), 32'd0);
    check("rst m_a3", 32'(m_a3), 32'd0);
    check("rst w_a3", 32'(w_a3), 32'd0);
`ifdef TNEW_STALL_CNT_EN
    check("rst stall_cnt", stall_cnt, 32'd0);
`endif
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Random traffic over a small register window so matches are frequent.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 6),
            $urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 7));
      cycle($sformatf("rnd%0d", n), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
